// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the NPC instruction fetch stage.
// Bus layout and FSM encoding live here so decode and checkers can import them.
package fetch_stage_pkg;

  localparam int          FETCH_DECODE_BUS_WIDTH = 64;
  localparam logic [31:0] RESET_PC_DEFAULT       = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_inst_queue.sv
// Small synchronous FIFO holding fetched {pc, inst} entries for decode.
// Pointer-plus-count; flush empties it in one cycle and overrides push/pop.
module fetch_inst_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A full queue may still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps one imem read in flight and buffers
// returned words for decode. Handshakes: imem request completes on valid&&ready;
// decode consumes the head when fetch_valid_o && !stall_i && !redirect_valid_i.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  output logic                              imem_req_valid_o,
  input  logic                              imem_req_ready_i,
  output logic [31:0]                       imem_addr_o,
  input  logic                              imem_rsp_valid_i,
  input  logic [31:0]                       imem_rsp_data_i,
  input  logic                              redirect_valid_i,
  input  logic [31:0]                       redirect_pc_i,
  input  logic                              stall_i,
  output logic                              fetch_valid_o,
  output logic [FETCH_DECODE_BUS_WIDTH-1:0] fetch_decode_bus_o,
  output fetch_state_e                      state_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q;
  logic         req_hs;
  logic         q_push, q_pop, q_full, q_empty;
  fetch_entry_t q_head, q_in;

  // Request depends only on registered state and occupancy, never on stall/redirect.
  assign imem_req_valid_o = (state_q == ST_REQ) && !q_full;
  assign imem_addr_o      = pc_q;
  assign req_hs           = imem_req_valid_o && imem_req_ready_i;
  assign state_o          = state_q;

  assign q_in   = '{pc: req_pc_q, inst: imem_rsp_data_i};
  assign q_push = (state_q == ST_WAIT) && imem_rsp_valid_i && !redirect_valid_i;
  assign q_pop  = !q_empty && !stall_i && !redirect_valid_i;

  assign fetch_valid_o      = !q_empty;
  assign fetch_decode_bus_o = q_empty ? '0 : q_head;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid_i) pc_d = {redirect_pc_i[31:2], 2'b00};
    else if (req_hs)      pc_d = pc_q + 32'd4;
    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (req_hs) state_d = redirect_valid_i ? ST_DROP : ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rsp_valid_i)      state_d = ST_REQ;
        else if (redirect_valid_i) state_d = ST_DROP;
      end
      ST_DROP: begin
        if (imem_rsp_valid_i) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (req_hs) req_pc_q <= pc_q;
    end
  end

  fetch_inst_queue #(
    .DEPTH(QUEUE_DEPTH),
    .WIDTH(FETCH_DECODE_BUS_WIDTH)
  ) u_queue (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .push     (q_push),
    .push_data(q_in),
    .pop      (q_pop),
    .flush    (redirect_valid_i),
    .full     (q_full),
    .empty    (q_empty),
    .head     (q_head)
  );

endmodule
